// File: rtl/mips_mem_bus_if.sv
// Avalon-MM bus between mips_mem_bus_ctrl (master) and the memory slave.
interface mips_mem_bus_if #(
  parameter int ADDR_W = 32
) ();
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [3:0]        byteenable;
  logic [31:0]       writedata;
  logic              waitrequest;
  logic [31:0]       readdata;

  modport master (
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_mem_bus_ctrl.sv
// Memory-side controller for the multi-cycle MIPS core: fetch in FETCH, load/store in EXEC2.
// Optional stall counter enabled by defining MEM_IF_STALL_COUNT_EN.

module mips_mem_bus_lane #(
  parameter int LANE_IDX = 0,
  parameter int LANE_W   = 8
) (
  input  logic [1:0]        size,
  input  logic [1:0]        off,
  input  logic [LANE_W-1:0] b_src,
  input  logic [LANE_W-1:0] h_src,
  input  logic [LANE_W-1:0] w_src,
  output logic              be,
  output logic [LANE_W-1:0] wd
);
  localparam logic [1:0] IDX = LANE_IDX[1:0];

  always_comb begin
    be = 1'b0;
    wd = '0;
    case (size)
      2'b00: begin be = (off == IDX);       wd = b_src; end
      2'b01: begin be = (off[1] == IDX[1]); wd = h_src; end
      2'b10: begin be = 1'b1;               wd = w_src; end
      default: ;
    endcase
  end
endmodule

module mips_mem_bus_ctrl #(
  parameter int          ADDR_W            = 32,
  parameter logic [31:0] RESET_VECTOR_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        s,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_read_req,
  input  logic              mem_write_req,
  input  logic [1:0]        mem_size,
  input  logic              mem_signed,
  input  logic [31:0]       mem_wdata,
  mips_mem_bus_if.master    bus,
  output logic [31:0]       instr,
  output logic [31:0]       load_data,
  output logic              misalign_err,
  output logic [31:0]       stall_cycles
);
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_EXEC1 = 2'b01,
    S_EXEC2 = 2'b10,
    S_HALT  = 2'b11
  } state_e;

  typedef struct packed {
    logic                               rd;
    logic                               wr;
    logic [ADDR_W-1:0]                  addr;
    logic [NUM_LANES-1:0]               be;
    logic [NUM_LANES-1:0][LANE_W-1:0]   wd;
  } req_t;

  state_e st;
  state_e s_prev_q, s_prev_d;
  logic   done_q, done_d;
  logic   misalign_err_q, misalign_err_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] load_data_q, load_data_d;

  logic [1:0] off;
  logic       done_eff, size_ok, fetch_go, exec_act, exec_go, err, accept;
  logic [NUM_LANES-1:0]             lane_be;
  logic [NUM_LANES-1:0][LANE_W-1:0] lane_wd;
  req_t        req;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;
  logic        unused_pc;

  assign st        = state_e'(s);
  assign off       = mem_addr[1:0];
  assign unused_pc = ^pc[1:0];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mips_mem_bus_lane #(.LANE_IDX(i), .LANE_W(LANE_W)) u_lane (
      .size  (mem_size),
      .off   (off),
      .b_src (mem_wdata[LANE_W-1:0]),
      .h_src (mem_wdata[LANE_W*(i%2) +: LANE_W]),
      .w_src (mem_wdata[LANE_W*i +: LANE_W]),
      .be    (lane_be[i]),
      .wd    (lane_wd[i])
    );
  end

  // A stale done from the previous state visit must not block the first cycle of a new one.
  always_comb begin
    done_eff = done_q && (st == s_prev_q);
    case (mem_size)
      2'b00:   size_ok = 1'b1;
      2'b01:   size_ok = !off[0];
      2'b10:   size_ok = (off == 2'b00);
      default: size_ok = 1'b0;
    endcase
    fetch_go = (st == S_FETCH) && !done_eff;
    exec_act = (st == S_EXEC2) && !done_eff;
    exec_go  = exec_act && (mem_read_req ^ mem_write_req) && size_ok;
    err      = exec_act && ((mem_read_req && mem_write_req) ||
                            ((mem_read_req || mem_write_req) && !size_ok));

    req = '0;
    if (fetch_go) begin
      req.rd   = 1'b1;
      req.addr = {pc[ADDR_W-1:2], 2'b00};
      req.be   = '1;
    end else if (exec_go) begin
      req.rd   = mem_read_req;
      req.wr   = mem_write_req;
      req.addr = {mem_addr[ADDR_W-1:2], 2'b00};
      req.be   = mem_read_req ? '1 : lane_be;
      req.wd   = mem_write_req ? lane_wd : '0;
    end
    // Reset kills the bus immediately, even in the middle of a stalled transfer.
    if (!rst) req = '0;

    accept = (req.rd || req.wr) && !bus.waitrequest;
  end

  always_comb begin
    ld_b = bus.readdata[{off, 3'b000} +: 8];
    ld_h = bus.readdata[{off[1], 4'b0000} +: 16];
    case (mem_size)
      2'b00:   ld_ext = {{24{mem_signed & ld_b[7]}}, ld_b};
      2'b01:   ld_ext = {{16{mem_signed & ld_h[15]}}, ld_h};
      default: ld_ext = bus.readdata;
    endcase
  end

  always_comb begin
    s_prev_d       = st;
    instr_d        = (fetch_go && accept) ? bus.readdata : instr_q;
    load_data_d    = (exec_go && mem_read_req && accept) ? ld_ext : load_data_q;
    misalign_err_d = misalign_err_q | err;
    done_d         = done_q;
    if (st != s_prev_q) done_d = 1'b0;
    // An acceptance on the first edge of a visit belongs to that visit.
    if (accept || err)  done_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_prev_q       <= S_FETCH;
      done_q         <= 1'b0;
      misalign_err_q <= 1'b0;
      instr_q        <= RESET_VECTOR_WORD;
      load_data_q    <= '0;
    end else begin
      s_prev_q       <= s_prev_d;
      done_q         <= done_d;
      misalign_err_q <= misalign_err_d;
      instr_q        <= instr_d;
      load_data_q    <= load_data_d;
    end
  end

`ifdef MEM_IF_STALL_COUNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((req.rd || req.wr) && bus.waitrequest) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

  assign bus.address    = req.addr;
  assign bus.read       = req.rd;
  assign bus.write      = req.wr;
  assign bus.byteenable = req.be;
  assign bus.writedata  = req.wd;
  assign instr          = instr_q;
  assign load_data      = load_data_q;
  assign misalign_err   = misalign_err_q;
endmodule
